shift_pipe_n: RTL and testbench
===============================

Name: shift_pipe_n

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 32-bit combinational left/right shifter.
- Adds the following over that block:
  - configurable data width;
  - configurable pipeline depth;
  - four shift modes: logical right, logical left, arithmetic right, rotate left;
  - a valid/ready handshake with backpressure;
  - a zero flag on the result.
- Sits between the register file operand path and the ALU result mux, as the shift unit of the datapath.

Parameters:
- WIDTH, 32: data width in bits. Must be a power of two, at least 4.
- SHAMT_W, 32: width of the shift-amount port. The full value is evaluated.
- STAGES, 2: number of register stages, 1..log2(WIDTH). Equals the latency in cycles.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- IN_VALID  in  1  input operation valid.
- IN_READY  out  1  block can accept an operation this cycle.
- D  in  WIDTH  data to shift.
- S  in  SHAMT_W  shift amount, unsigned.
- MODE  in  2  shift mode: 00 SRL, 01 SLL, 10 SRA, 11 ROL.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- Y  out  WIDTH  shifted result.
- ZERO  out  1  Y equals 0.

Behaviour:
- Reset: RST sampled low at a rising edge clears every stage valid bit. OUT_VALID=0, Y=0, ZERO=1 from that edge on.
  - Reset mid-operation discards all in-flight operations. Nothing is replayed.
  - IN_READY=1 after reset.
- Acceptance: an operation is accepted at a rising edge where IN_VALID && IN_READY.
- Advance: the pipeline has a single global enable, ADV = OUT_READY || !OUT_VALID.
  - IN_READY = ADV (combinational).
  - When ADV=1, every stage loads from its predecessor. Stage 0 loads D/S/MODE and valid=IN_VALID, so bubbles propagate.
  - When ADV=0, all stages hold and Y/ZERO/OUT_VALID are stable.
- Latency: an operation accepted at edge n with no stalls shows OUT_VALID=1 after edge n+STAGES-1.
  - With STAGES=1, the shift is combinational into the output register.
  - Each stall cycle adds one cycle.
- Throughput: one operation per cycle while OUT_READY=1.
- Mux levels: the log2(WIDTH) mux levels are split across the STAGES stages, earliest stages taking any remainder. The split is an implementation choice, but latency is exactly STAGES.
- Amount handling: let K = S as an unsigned SHAMT_W value.
  - SRL: Y = D >> K, zero fill. Y=0 if K >= WIDTH.
  - SLL: Y = D << K, zero fill. Y=0 if K >= WIDTH.
  - SRA: Y = D >> K, filled with D[WIDTH-1]. If K >= WIDTH, Y = all bits equal to D[WIDTH-1].
  - ROL: Y = D rotated left by (K mod WIDTH). K=WIDTH returns D.
- K >= WIDTH detection: upper bits of S (bits SHAMT_W-1 down to log2(WIDTH)) are OR-reduced in stage 0 and carried as a saturate flag.
- K=0: Y=D for all modes.
- ZERO: registered alongside Y, in the same stage as Y, reflecting the same operation.
- Idle output: when OUT_VALID=0, Y/ZERO hold their last values. Consumers must ignore them.
- Handshake rules:
  - Simultaneous accept of a new input and drain of the output in the same cycle is legal and loses nothing.
  - Once OUT_VALID=1, Y must not change until OUT_READY=1.

Test Plan:
- Reset and latency (WIDTH=32, STAGES=2, OUT_READY=1): assert RST=0 for 2 cycles, then accept D=32'h1, S=1, MODE=01 at edge n. Required: OUT_VALID=0 and ZERO=1 during reset; OUT_VALID=1 with Y=32'h2 after edge n+1, and ZERO=0.
- Modes, back to back, one per cycle (D=32'h80000000, S=31):
  - SRL -> 32'h1
  - SLL -> 32'h0 with ZERO=1
  - SRA -> 32'hFFFFFFFF
  - ROL -> 32'h40000000
  - Required: 4 consecutive OUT_VALID cycles, in order.
- Saturation: D=32'hFFFFFFFF with S=32, S=32'h80000000, S=33. Required:
  - SRL -> 0
  - SLL -> 0
  - SRA -> 32'hFFFFFFFF
  - ROL with S=32 -> 32'hFFFFFFFF
  - ROL with S=33 -> 32'hFFFFFFFF
- Backpressure: stream 5 ops (D=1, S=0..4, SLL), with OUT_READY held low for 3 cycles after the first result appears. Required:
  - IN_READY=0 while stalled;
  - Y holds 32'h1 during the stall;
  - results 1, 2, 4, 8, 16 in order, no loss or duplication.
- Reset mid-stream: reset asserted with 2 ops in flight. Required: OUT_VALID=0 on the next cycle, and neither op ever emerges.
- Parameter sweep: WIDTH=8 with STAGES=1 and STAGES=3. Checks:
  - D=8'hA5, S=4, ROL -> 8'h5A
  - SRA S=9 on 8'h80 -> 8'hFF
  - Required latency: 1 and 3 cycles respectively.

Source files
------------

// File: rtl/shift_pipe_n.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROL) with valid/ready handshake and zero flag.
// The log2(WIDTH) mux levels are spread across STAGES register stages, earliest stages first.
module shift_pipe_n #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 32,
   parameter int unsigned STAGES  = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [WIDTH-1:0]   D,
   input  logic [SHAMT_W-1:0] S,
   input  logic [1:0]         MODE,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [WIDTH-1:0]   Y,
   output logic               ZERO
);

   localparam int unsigned LVLS   = $clog2(WIDTH);
   localparam int unsigned LIDX_W = $clog2(LVLS);
   localparam int unsigned BASE   = LVLS / STAGES;
   localparam int unsigned REM    = LVLS % STAGES;

   typedef enum logic [1:0] {
      M_SRL = 2'b00,
      M_SLL = 2'b01,
      M_SRA = 2'b10,
      M_ROL = 2'b11
   } mode_e;

   // First mux level handled by stage stg; the first REM stages take one extra level.
   function automatic int unsigned lvl_first(input int unsigned stg);
      return stg * BASE + ((stg < REM) ? stg : REM);
   endfunction

   // Apply mux levels lo..hi-1 of the shift; each level shifts by 2**k when amt[k] is set.
   function automatic logic [WIDTH-1:0] shift_levels(
      input logic [WIDTH-1:0] d,
      input logic [LVLS-1:0]  amt,
      input mode_e            m,
      input int unsigned      lo,
      input int unsigned      hi
   );
      logic [WIDTH-1:0] v;
      v = d;
      for (int unsigned k = 0; k < LVLS; k++) begin
         if (k >= lo && k < hi && amt[LIDX_W'(k)]) begin
            case (m)
               M_SRL:   v = v >> (1 << k);
               M_SLL:   v = v << (1 << k);
               M_SRA:   v = $signed(v) >>> (1 << k);
               default: v = (v << (1 << k)) | (v >> (WIDTH - (1 << k)));
            endcase
         end
      end
      return v;
   endfunction

   // Out-of-range amounts; SRA keeps the sign in the MSB through every level, so it is the fill.
   function automatic logic [WIDTH-1:0] saturate(
      input logic [WIDTH-1:0] v,
      input mode_e            m,
      input logic             sat
   );
      if (!sat) begin
         return v;
      end
      case (m)
         M_SRL, M_SLL: return '0;
         M_SRA:        return {WIDTH{v[WIDTH-1]}};
         default:      return v;
      endcase
   endfunction

   logic                           w_adv;
   logic                           w_sat0;
   logic [LVLS-1:0]                w_amt0;
   logic [STAGES-1:0][WIDTH-1:0]   w_in_data;
   logic [STAGES-1:0][LVLS-1:0]    w_in_amt;
   logic [STAGES-1:0][1:0]         w_in_mode;
   logic [STAGES-1:0]              w_in_sat;
   logic [STAGES-1:0]              w_in_vld;

   // Single global advance: the whole pipe moves whenever the output slot can be refilled.
   assign w_adv    = OUT_READY || !OUT_VALID;
   assign IN_READY = w_adv;

   if (SHAMT_W > LVLS) begin : g_sat
      assign w_sat0 = |S[SHAMT_W-1:LVLS];
      assign w_amt0 = S[LVLS-1:0];
   end else begin : g_nosat
      assign w_sat0 = 1'b0;
      assign w_amt0 = LVLS'(S);
   end

   assign w_in_data[0] = D;
   assign w_in_amt[0]  = w_amt0;
   assign w_in_mode[0] = MODE;
   assign w_in_sat[0]  = w_sat0;
   assign w_in_vld[0]  = IN_VALID;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int unsigned LO = lvl_first(s);
      localparam int unsigned HI = lvl_first(s + 1);

      logic [WIDTH-1:0] w_shift;

      assign w_shift = shift_levels(w_in_data[s], w_in_amt[s], mode_e'(w_in_mode[s]), LO, HI);

      if (s < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] r_data;
         logic [LVLS-1:0]  r_amt;
         logic [1:0]       r_mode;
         logic             r_sat;
         logic             r_vld;

         // Payload only loads for real operations so bubbles leave stale data untouched.
         always_ff @(posedge CLK) begin
            if (!RST) begin
               r_vld  <= 1'b0;
               r_data <= '0;
               r_amt  <= '0;
               r_mode <= 2'b00;
               r_sat  <= 1'b0;
            end else if (w_adv) begin
               r_vld <= w_in_vld[s];
               if (w_in_vld[s]) begin
                  r_data <= w_shift;
                  r_amt  <= w_in_amt[s];
                  r_mode <= w_in_mode[s];
                  r_sat  <= w_in_sat[s];
               end
            end
         end

         assign w_in_data[s+1] = r_data;
         assign w_in_amt[s+1]  = r_amt;
         assign w_in_mode[s+1] = r_mode;
         assign w_in_sat[s+1]  = r_sat;
         assign w_in_vld[s+1]  = r_vld;
      end else begin : g_last
         logic [WIDTH-1:0] w_res;
         logic [WIDTH-1:0] r_y;
         logic             r_zero;
         logic             r_vld;

         assign w_res = saturate(w_shift, mode_e'(w_in_mode[s]), w_in_sat[s]);

         // Output register; Y and ZERO hold across bubbles and stalls.
         always_ff @(posedge CLK) begin
            if (!RST) begin
               r_vld  <= 1'b0;
               r_y    <= '0;
               r_zero <= 1'b1;
            end else if (w_adv) begin
               r_vld <= w_in_vld[s];
               if (w_in_vld[s]) begin
                  r_y    <= w_res;
                  r_zero <= (w_res == '0);
               end
            end
         end

         assign Y         = r_y;
         assign ZERO      = r_zero;
         assign OUT_VALID = r_vld;
      end
   end

endmodule

// File: tb/tb_shift_pipe_n.sv
// Self-checking bench for shift_pipe_n: directed scenarios plus a randomized scoreboard run
// on a 32-bit/2-stage instance, and latency/value checks on 8-bit 1- and 3-stage instances.
module tb_shift_pipe_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   // 32-bit, 2-stage instance
   logic        a_vld, a_rdy, a_ovld, a_ordy, a_zero;
   logic [31:0] a_d, a_s, a_y;
   logic [1:0]  a_m;

   // 8-bit instances sharing one input bundle
   logic        b_vld, b_ordy;
   logic [7:0]  b_d;
   logic [31:0] b_s;
   logic [1:0]  b_m;
   logic        p_rdy, p_ovld, p_zero, q_rdy, q_ovld, q_zero;
   logic [7:0]  p_y, q_y;

   shift_pipe_n #(.WIDTH(32), .SHAMT_W(32), .STAGES(2)) u_w32 (
      .CLK(clk), .RST(rst_n), .IN_VALID(a_vld), .IN_READY(a_rdy), .D(a_d), .S(a_s),
      .MODE(a_m), .OUT_VALID(a_ovld), .OUT_READY(a_ordy), .Y(a_y), .ZERO(a_zero));

   shift_pipe_n #(.WIDTH(8), .SHAMT_W(32), .STAGES(1)) u_w8s1 (
      .CLK(clk), .RST(rst_n), .IN_VALID(b_vld), .IN_READY(p_rdy), .D(b_d), .S(b_s),
      .MODE(b_m), .OUT_VALID(p_ovld), .OUT_READY(b_ordy), .Y(p_y), .ZERO(p_zero));

   shift_pipe_n #(.WIDTH(8), .SHAMT_W(32), .STAGES(3)) u_w8s3 (
      .CLK(clk), .RST(rst_n), .IN_VALID(b_vld), .IN_READY(q_rdy), .D(b_d), .S(b_s),
      .MODE(b_m), .OUT_VALID(q_ovld), .OUT_READY(b_ordy), .Y(q_y), .ZERO(q_zero));

   // Reference: the shift rules written directly as 32-bit arithmetic.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] k,
                                             input logic [1:0] m);
      logic [31:0] r;
      int          n;
      case (m)
         2'b00: r = (k >= 32) ? 32'h0 : d >> k;
         2'b01: r = (k >= 32) ? 32'h0 : d << k;
         2'b10: begin
            if (k >= 32) r = d[31] ? 32'hFFFF_FFFF : 32'h0;
            else         r = (d >> k) | (d[31] ? ~(32'hFFFF_FFFF >> k) : 32'h0);
         end
         default: begin
            n = int'(k % 32);
            r = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
         end
      endcase
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; a_ordy = 1'b1; a_vld = 1'b0;
      tick; tick;
      n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_ovld); end
      n_vec++; if (a_zero !== 1'b1) begin n_err++; $display("FAIL rst_zero: got %b want 1", a_zero); end
      n_vec++; if (a_y !== 32'h0) begin n_err++; $display("FAIL rst_y: got %h want 0", a_y); end
      n_vec++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_rdy); end
      rst_n = 1'b1; a_vld = 1'b1; a_d = 32'h1; a_s = 32'd1; a_m = 2'b01;
      tick;
      a_vld = 1'b0;
      n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", a_ovld); end
      tick;
      n_vec++; if (a_ovld !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b want 1", a_ovld); end
      n_vec++; if (a_y !== 32'h2) begin n_err++; $display("FAIL lat_y: got %h want 00000002", a_y); end
      n_vec++; if (a_zero !== 1'b0) begin n_err++; $display("FAIL lat_zero: got %b want 0", a_zero); end
      tick;
      n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL lat_bubble: got %b want 0", a_ovld); end
   endtask

   task automatic test_modes;
      logic [31:0] exp_y [4];
      int          got   = 0;
      int          first = -1;
      exp_y[0] = 32'h1; exp_y[1] = 32'h0; exp_y[2] = 32'hFFFF_FFFF; exp_y[3] = 32'h4000_0000;
      a_ordy = 1'b1; a_d = 32'h8000_0000; a_s = 32'd31;
      for (int c = 0; c < 8; c++) begin
         a_vld = (c < 4); a_m = 2'(c);
         tick;
         if (a_ovld) begin
            if (first < 0) first = c;
            n_vec++;
            if (got >= 4) begin
               n_err++; $display("FAIL modes_extra: got %h want no output", a_y);
            end else begin
               if (a_y !== exp_y[got] || a_zero !== (exp_y[got] == 32'h0)) begin
                  n_err++; $display("FAIL modes_y[%0d]: got %h/%b want %h/%b", got, a_y, a_zero,
                                    exp_y[got], exp_y[got] == 32'h0);
               end
               n_vec++;
               if (c != first + got) begin
                  n_err++; $display("FAIL modes_gap: got cycle %0d want %0d", c, first + got);
               end
            end
            got++;
         end
      end
      n_vec++; if (got != 4) begin n_err++; $display("FAIL modes_count: got %0d want 4", got); end
   endtask

   task automatic test_saturation;
      logic [31:0] ks [3];
      logic [31:0] td [14], ts [14], te [14];
      logic [1:0]  tm [14];
      int          got = 0;
      ks[0] = 32'd32; ks[1] = 32'h8000_0000; ks[2] = 32'd33;
      for (int i = 0; i < 12; i++) begin
         td[i] = 32'hFFFF_FFFF; tm[i] = 2'(i / 3); ts[i] = ks[i % 3];
         te[i] = (i >= 6) ? 32'hFFFF_FFFF : 32'h0;
      end
      td[12] = 32'h1; ts[12] = 32'd32; tm[12] = 2'b11; te[12] = 32'h1;
      td[13] = 32'h1; ts[13] = 32'd33; tm[13] = 2'b11; te[13] = 32'h2;
      a_ordy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         a_vld = (c < 14);
         if (c < 14) begin a_d = td[c]; a_s = ts[c]; a_m = tm[c]; end
         tick;
         if (a_ovld) begin
            n_vec++;
            if (got >= 14) begin
               n_err++; $display("FAIL sat_extra: got %h want no output", a_y);
            end else if (a_y !== te[got] || a_zero !== (te[got] == 32'h0)) begin
               n_err++; $display("FAIL sat[%0d]: got %h/%b want %h/%b", got, a_y, a_zero,
                                 te[got], te[got] == 32'h0);
            end
            got++;
         end
      end
      n_vec++; if (got != 14) begin n_err++; $display("FAIL sat_count: got %0d want 14", got); end
   endtask

   task automatic test_backpressure;
      int sent = 0, got = 0, stall_left = 0, stalls = 0;
      bit seen = 1'b0;
      bit acc;
      a_m = 2'b01; a_d = 32'h1;
      for (int c = 0; c < 40 && got < 5; c++) begin
         a_vld = (sent < 5); a_s = 32'(sent);
         if (a_ovld && !seen) begin seen = 1'b1; stall_left = 3; end
         if (stall_left > 0) begin a_ordy = 1'b0; stall_left--; end
         else a_ordy = 1'b1;
         #1;
         if (!a_ordy) begin
            stalls++;
            n_vec++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", a_rdy); end
            n_vec++;
            if (a_ovld !== 1'b1 || a_y !== 32'h1) begin
               n_err++; $display("FAIL bp_hold: got %b/%h want 1/00000001", a_ovld, a_y);
            end
         end
         if (a_ovld && a_ordy) begin
            n_vec++;
            if (a_y !== (32'h1 << got)) begin
               n_err++; $display("FAIL bp_result[%0d]: got %h want %h", got, a_y, 32'h1 << got);
            end
            got++;
         end
         acc = a_vld && a_rdy;
         tick;
         if (acc) sent++;
      end
      n_vec++; if (got != 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got); end
      n_vec++; if (stalls != 3) begin n_err++; $display("FAIL bp_stalls: got %0d want 3", stalls); end
      a_ordy = 1'b1; a_vld = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick;
         n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL bp_dup: got %b/%h want 0", a_ovld, a_y); end
      end
   endtask

   task automatic test_reset_midstream;
      a_ordy = 1'b1; a_vld = 1'b1; a_d = 32'h3; a_s = 32'd1; a_m = 2'b01;
      tick;
      a_d = 32'h5;
      tick;
      a_vld = 1'b0; rst_n = 1'b0;
      tick;
      n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", a_ovld); end
      n_vec++;
      if (a_y !== 32'h0 || a_zero !== 1'b1) begin
         n_err++; $display("FAIL mid_rst_y: got %h/%b want 00000000/1", a_y, a_zero);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick;
         n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL mid_rst_ghost: got %b/%h want 0", a_ovld, a_y); end
      end
   endtask

   task automatic test_random;
      logic [31:0] q [$];
      logic [31:0] exp_v, held = 32'h0;
      bit          hold_chk = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (c >= 400 && q.size() == 0) break;
         a_ordy = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         a_vld  = (c < 400) && ($urandom_range(0, 2) != 0);
         a_d    = $urandom;
         a_m    = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a_s = $urandom_range(0, 31);
            1:       a_s = $urandom_range(32, 40);
            2:       a_s = $urandom;
            default: a_s = 32'h0;
         endcase
         #1;
         if (hold_chk) begin
            n_vec++;
            if (a_ovld !== 1'b1 || a_y !== held) begin
               n_err++; $display("FAIL rnd_hold: got %b/%h want 1/%h", a_ovld, a_y, held);
            end
         end
         n_vec++;
         if (a_rdy !== (a_ordy || !a_ovld)) begin
            n_err++; $display("FAIL rnd_in_ready: got %b want %b", a_rdy, a_ordy || !a_ovld);
         end
         if (a_ovld && a_ordy) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL rnd_extra: got %h want no output", a_y);
            end else begin
               exp_v = q.pop_front();
               if (a_y !== exp_v || a_zero !== (exp_v == 32'h0)) begin
                  n_err++; $display("FAIL rnd_y: got %h/%b want %h/%b", a_y, a_zero, exp_v, exp_v == 32'h0);
               end
            end
         end
         if (a_vld && a_rdy) q.push_back(ref_shift(a_d, a_s, a_m));
         hold_chk = a_ovld && !a_ordy;
         held     = a_y;
         tick;
      end
      n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
      a_vld = 1'b0; a_ordy = 1'b1;
   endtask

   task automatic test_param_sweep;
      b_ordy = 1'b1; b_vld = 1'b1; b_d = 8'hA5; b_s = 32'd4; b_m = 2'b11;
      tick;
      b_d = 8'h80; b_s = 32'd9; b_m = 2'b10;
      n_vec++; if (p_ovld !== 1'b1 || p_y !== 8'h5A || p_zero !== 1'b0) begin
         n_err++; $display("FAIL s1_rol: got %b/%h/%b want 1/5a/0", p_ovld, p_y, p_zero); end
      n_vec++; if (q_ovld !== 1'b0) begin n_err++; $display("FAIL s3_early1: got %b want 0", q_ovld); end
      tick;
      b_vld = 1'b1; b_d = 8'h01; b_s = 32'd8; b_m = 2'b01;
      n_vec++; if (p_ovld !== 1'b1 || p_y !== 8'hFF) begin
         n_err++; $display("FAIL s1_sra: got %b/%h want 1/ff", p_ovld, p_y); end
      n_vec++; if (q_ovld !== 1'b0) begin n_err++; $display("FAIL s3_early2: got %b want 0", q_ovld); end
      tick;
      b_vld = 1'b0;
      n_vec++; if (p_ovld !== 1'b1 || p_y !== 8'h00 || p_zero !== 1'b1) begin
         n_err++; $display("FAIL s1_sll_sat: got %b/%h/%b want 1/00/1", p_ovld, p_y, p_zero); end
      n_vec++; if (q_ovld !== 1'b1 || q_y !== 8'h5A) begin
         n_err++; $display("FAIL s3_rol: got %b/%h want 1/5a", q_ovld, q_y); end
      tick;
      n_vec++; if (p_ovld !== 1'b0) begin n_err++; $display("FAIL s1_bubble: got %b want 0", p_ovld); end
      n_vec++; if (q_ovld !== 1'b1 || q_y !== 8'hFF) begin
         n_err++; $display("FAIL s3_sra: got %b/%h want 1/ff", q_ovld, q_y); end
      tick;
      n_vec++; if (q_ovld !== 1'b1 || q_y !== 8'h00 || q_zero !== 1'b1) begin
         n_err++; $display("FAIL s3_sll_sat: got %b/%h/%b want 1/00/1", q_ovld, q_y, q_zero); end
      tick;
      n_vec++; if (q_ovld !== 1'b0) begin n_err++; $display("FAIL s3_bubble: got %b want 0", q_ovld); end
   endtask

   initial begin
      rst_n = 1'b0;
      a_vld = 1'b0; a_d = 32'h0; a_s = 32'h0; a_m = 2'b00; a_ordy = 1'b1;
      b_vld = 1'b0; b_d = 8'h0;  b_s = 32'h0; b_m = 2'b00; b_ordy = 1'b1;
      test_reset;
      test_modes;
      test_saturation;
      test_backpressure;
      test_reset_midstream;
      test_random;
      test_param_sweep;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
